// File: rtl/dram_arbiter_if.sv
// Bundled cache-side, DRAM-side and status signals of dram_arbiter.
// slave = arbiter view, master = surrounding caches/FIFO view.
interface dram_arbiter_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 128
);
  logic              m0_req_valid;
  logic              m0_req_ready;
  logic              m0_req_we;
  logic [ADDR_W-1:0] m0_req_addr;
  logic [DATA_W-1:0] m0_req_wdata;
  logic              m0_resp_valid;
  logic [DATA_W-1:0] m0_resp_rdata;
  logic              m1_req_valid;
  logic              m1_req_ready;
  logic              m1_req_we;
  logic [ADDR_W-1:0] m1_req_addr;
  logic [DATA_W-1:0] m1_req_wdata;
  logic              m1_resp_valid;
  logic [DATA_W-1:0] m1_resp_rdata;
  logic              dram_req_valid;
  logic              dram_req_ready;
  logic              dram_req_we;
  logic [ADDR_W-1:0] dram_req_addr;
  logic [DATA_W-1:0] dram_req_wdata;
  logic              dram_resp_valid;
  logic [DATA_W-1:0] dram_resp_rdata;
  logic              busy;
  logic              owner;
  logic              err;

  modport slave (
    input  m0_req_valid, m0_req_we, m0_req_addr, m0_req_wdata,
    output m0_req_ready, m0_resp_valid, m0_resp_rdata,
    input  m1_req_valid, m1_req_we, m1_req_addr, m1_req_wdata,
    output m1_req_ready, m1_resp_valid, m1_resp_rdata,
    output dram_req_valid, dram_req_we, dram_req_addr, dram_req_wdata,
    input  dram_req_ready, dram_resp_valid, dram_resp_rdata,
    output busy, owner, err
  );

  modport master (
    output m0_req_valid, m0_req_we, m0_req_addr, m0_req_wdata,
    input  m0_req_ready, m0_resp_valid, m0_resp_rdata,
    output m1_req_valid, m1_req_we, m1_req_addr, m1_req_wdata,
    input  m1_req_ready, m1_resp_valid, m1_resp_rdata,
    input  dram_req_valid, dram_req_we, dram_req_addr, dram_req_wdata,
    output dram_req_ready, dram_resp_valid, dram_resp_rdata,
    input  busy, owner, err
  );
endinterface

// File: rtl/dram_arbiter.sv
// Two-port round-robin arbiter for the DRAM request channel, one transaction in flight.
// Optional read-response watchdog enabled by defining DRAM_ARB_WATCHDOG_EN.
module dram_arbiter #(
  parameter int ADDR_W      = 27,
  parameter int DATA_W      = 128,
  parameter int WDOG_CYCLES = 1023
) (
  input  logic           clk,
  input  logic           rst,
  dram_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_prio;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_resp0;
  logic              r_resp1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              w_winner;
  logic              w_grant;
  logic              w_resp_take;
  logic              w_timeout;
  logic              w_wdog_hit;
  logic              w_done;

  // Both valid: the priority pointer decides; otherwise the lone requester wins.
  assign w_winner = (bus.m0_req_valid & bus.m1_req_valid) ? r_prio : bus.m1_req_valid;
  assign w_grant  = (r_state == S_IDLE) & (bus.m0_req_valid | bus.m1_req_valid) & ~rst;
  assign w_done   = w_resp_take | w_timeout;

  assign bus.m0_req_ready   = w_grant & ~w_winner;
  assign bus.m1_req_ready   = w_grant & w_winner;
  assign bus.dram_req_valid = (r_state == S_ISSUE);
  assign bus.dram_req_we    = r_we;
  assign bus.dram_req_addr  = r_addr;
  assign bus.dram_req_wdata = r_wdata;
  assign bus.m0_resp_valid  = r_resp0;
  assign bus.m0_resp_rdata  = r_rdata0;
  assign bus.m1_resp_valid  = r_resp1;
  assign bus.m1_resp_rdata  = r_rdata1;
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.owner          = r_owner;

`ifdef DRAM_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
  logic [CNT_W-1:0] r_wdog_cnt;
  logic             r_err;

  assign w_wdog_hit = (r_wdog_cnt == CNT_W'(WDOG_CYCLES));
  assign bus.err    = r_err;

  // Watchdog counter (cleared while issuing, so it starts at 0 in WAIT) and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_wdog_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_wdog_cnt <= r_wdog_cnt + CNT_W'(1);
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused   = (WDOG_CYCLES == 0);
  assign w_wdog_hit = 1'b0;
  assign bus.err    = 1'b0;
`endif

  // Next-state logic; a real response beats a watchdog hit in the same cycle.
  always_comb begin
    w_next      = r_state;
    w_resp_take = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) w_next = S_ISSUE;
        else         w_next = S_IDLE;
      end
      S_ISSUE: begin
        if (bus.dram_req_ready) w_next = r_we ? S_IDLE : S_WAIT;
        else                    w_next = S_ISSUE;
      end
      S_WAIT: begin
        if (bus.dram_resp_valid) begin
          w_resp_take = 1'b1;
          w_next      = S_IDLE;
        end else if (w_wdog_hit) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end else begin
          w_next = S_WAIT;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, latched request, round-robin pointer and registered responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_prio   <= 1'b0;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_resp0  <= 1'b0;
      r_resp1  <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_we    <= w_winner ? bus.m1_req_we    : bus.m0_req_we;
        r_addr  <= w_winner ? bus.m1_req_addr  : bus.m0_req_addr;
        r_wdata <= w_winner ? bus.m1_req_wdata : bus.m0_req_wdata;
        r_owner <= w_winner;
        r_prio  <= ~w_winner;
      end
      r_resp0 <= w_done & ~r_owner;
      r_resp1 <= w_done & r_owner;
      if (w_done & ~r_owner) begin
        r_rdata0 <= w_resp_take ? bus.dram_resp_rdata : '0;
      end
      if (w_done & r_owner) begin
        r_rdata1 <= w_resp_take ? bus.dram_resp_rdata : '0;
      end
    end
  end
endmodule

// File: tb/tb_dram_arbiter.sv
// Directed self-checking bench for dram_arbiter; watchdog cases run when
// DRAM_ARB_WATCHDOG_EN is defined (WDOG_CYCLES = 8).
module tb_dram_arbiter;
  localparam int AW   = 27;
  localparam int DW   = 128;
  localparam int WDOG = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [DW-1:0] pat_a5;
  logic [DW-1:0] exp_d;

  always #5 clk = ~clk;

  dram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WDOG_CYCLES(WDOG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    bus.m0_req_valid    = 1'b0;
    bus.m0_req_we       = 1'b0;
    bus.m0_req_addr     = '0;
    bus.m0_req_wdata    = '0;
    bus.m1_req_valid    = 1'b0;
    bus.m1_req_we       = 1'b0;
    bus.m1_req_addr     = '0;
    bus.m1_req_wdata    = '0;
    bus.dram_resp_valid = 1'b0;
    bus.dram_resp_rdata = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    pat_a5 = {16{8'hA5}};
    rst = 1'b1;
    idle_inputs();
    bus.dram_req_ready = 1'b1;
    #1;
    check_eq("rst_busy",  128'(bus.busy),           128'd0);
    check_eq("rst_owner", 128'(bus.owner),          128'd0);
    check_eq("rst_err",   128'(bus.err),            128'd0);
    check_eq("rst_dvld",  128'(bus.dram_req_valid), 128'd0);
    check_eq("rst_daddr", 128'(bus.dram_req_addr),  128'd0);
    check_eq("rst_r0",    bus.m0_resp_rdata,        128'd0);
    check_eq("rst_rv1",   128'(bus.m1_resp_valid),  128'd0);
    tick();
    tick();
    rst = 1'b0;

    // Single read from m0
    bus.m0_req_valid = 1'b1;
    bus.m0_req_we    = 1'b0;
    bus.m0_req_addr  = 27'h0000100;
    #1;
    check_eq("rd_rdy0",  128'(bus.m0_req_ready),   128'd1);
    check_eq("rd_rdy1",  128'(bus.m1_req_ready),   128'd0);
    check_eq("rd_dvld0", 128'(bus.dram_req_valid), 128'd0);
    tick();
    bus.m0_req_valid = 1'b0;
    check_eq("rd_dvld",  128'(bus.dram_req_valid), 128'd1);
    check_eq("rd_daddr", 128'(bus.dram_req_addr),  128'h100);
    check_eq("rd_dwe",   128'(bus.dram_req_we),    128'd0);
    check_eq("rd_busy",  128'(bus.busy),           128'd1);
    check_eq("rd_rdy0b", 128'(bus.m0_req_ready),   128'd0);
    tick();
    check_eq("rd_wait_dvld", 128'(bus.dram_req_valid), 128'd0);
    tick();
    tick();
    bus.dram_resp_valid = 1'b1;
    bus.dram_resp_rdata = pat_a5;
    check_eq("rd_rv0_early", 128'(bus.m0_resp_valid), 128'd0);
    tick();
    bus.dram_resp_valid = 1'b0;
    check_eq("rd_rv0",   128'(bus.m0_resp_valid), 128'd1);
    check_eq("rd_data0", bus.m0_resp_rdata,        pat_a5);
    check_eq("rd_rv1",   128'(bus.m1_resp_valid), 128'd0);
    check_eq("rd_idle",  128'(bus.busy),           128'd0);
    tick();
    check_eq("rd_pulse0", 128'(bus.m0_resp_valid), 128'd0);
    check_eq("rd_pulse1", 128'(bus.m1_resp_valid), 128'd0);
    check_eq("rd_hold0",  bus.m0_resp_rdata,        pat_a5);

    // Contention: both hold valid reads from reset, expect 0,1,0,1
    bus.m0_req_valid = 1'b1;
    bus.m0_req_addr  = 27'h0000010;
    bus.m1_req_valid = 1'b1;
    bus.m1_req_addr  = 27'h0000020;
    rst = 1'b1;
    #1;
    check_eq("ct_rst_rdy0", 128'(bus.m0_req_ready), 128'd0);
    check_eq("ct_rst_rdy1", 128'(bus.m1_req_ready), 128'd0);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("ct_rdy0", 128'(bus.m0_req_ready), (k % 2 == 0) ? 128'd1 : 128'd0);
      check_eq("ct_rdy1", 128'(bus.m1_req_ready), (k % 2 == 1) ? 128'd1 : 128'd0);
      tick();
      check_eq("ct_owner", 128'(bus.owner),         (k % 2 == 1) ? 128'd1 : 128'd0);
      check_eq("ct_daddr", 128'(bus.dram_req_addr), (k % 2 == 1) ? 128'h20 : 128'h10);
      tick();
      exp_d = 128'h1000 + 128'(k);
      bus.dram_resp_valid = 1'b1;
      bus.dram_resp_rdata = exp_d;
      tick();
      bus.dram_resp_valid = 1'b0;
      check_eq("ct_rv0", 128'(bus.m0_resp_valid), (k % 2 == 0) ? 128'd1 : 128'd0);
      check_eq("ct_rv1", 128'(bus.m1_resp_valid), (k % 2 == 1) ? 128'd1 : 128'd0);
      if (k % 2 == 0) check_eq("ct_data0", bus.m0_resp_rdata, exp_d);
      else            check_eq("ct_data1", bus.m1_resp_rdata, exp_d);
    end
    bus.m0_req_valid = 1'b0;
    bus.m1_req_valid = 1'b0;
    tick();

    // m1 write held off by the FIFO for 5 cycles
    bus.dram_req_ready = 1'b0;
    bus.m1_req_valid   = 1'b1;
    bus.m1_req_we      = 1'b1;
    bus.m1_req_addr    = 27'h0000200;
    bus.m1_req_wdata   = 128'h1234;
    #1;
    check_eq("wr_rdy1", 128'(bus.m1_req_ready), 128'd1);
    check_eq("wr_rdy0", 128'(bus.m0_req_ready), 128'd0);
    tick();
    bus.m1_req_valid = 1'b0;
    bus.m1_req_we    = 1'b0;
    bus.m1_req_wdata = '0;
    for (int c = 0; c < 5; c++) begin
      check_eq("wr_dvld",  128'(bus.dram_req_valid), 128'd1);
      check_eq("wr_dwe",   128'(bus.dram_req_we),    128'd1);
      check_eq("wr_daddr", 128'(bus.dram_req_addr),  128'h200);
      check_eq("wr_wdata", bus.dram_req_wdata,        128'h1234);
      tick();
    end
    bus.dram_req_ready = 1'b1;
    check_eq("wr_busy_rdy", 128'(bus.busy), 128'd1);
    tick();
    check_eq("wr_idle",  128'(bus.busy),           128'd0);
    check_eq("wr_dvld0", 128'(bus.dram_req_valid), 128'd0);
    check_eq("wr_rv0",   128'(bus.m0_resp_valid),  128'd0);
    check_eq("wr_rv1",   128'(bus.m1_resp_valid),  128'd0);
    check_eq("wr_owner", 128'(bus.owner),          128'd1);

    // Reset while m1 read is waiting
    bus.m1_req_valid = 1'b1;
    bus.m1_req_addr  = 27'h0000300;
    #1;
    check_eq("rw_rdy1", 128'(bus.m1_req_ready), 128'd1);
    tick();
    bus.m1_req_valid = 1'b0;
    tick();
    check_eq("rw_busy_pre",  128'(bus.busy),  128'd1);
    check_eq("rw_owner_pre", 128'(bus.owner), 128'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rw_busy",  128'(bus.busy),           128'd0);
    check_eq("rw_owner", 128'(bus.owner),          128'd0);
    check_eq("rw_dvld",  128'(bus.dram_req_valid), 128'd0);
    check_eq("rw_daddr", 128'(bus.dram_req_addr),  128'd0);
    check_eq("rw_r1",    bus.m1_resp_rdata,        128'd0);
    check_eq("rw_r0",    bus.m0_resp_rdata,        128'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    bus.dram_resp_valid = 1'b1;
    bus.dram_resp_rdata = 128'hDEAD;
    tick();
    bus.dram_resp_valid = 1'b0;
    check_eq("rw_rv0",  128'(bus.m0_resp_valid), 128'd0);
    check_eq("rw_rv1",  128'(bus.m1_resp_valid), 128'd0);
    check_eq("rw_idle", 128'(bus.busy),          128'd0);
    check_eq("rw_r1b",  bus.m1_resp_rdata,       128'd0);

`ifdef DRAM_ARB_WATCHDOG_EN
    // Read with no response: timeout after 8 WAIT cycles
    bus.m0_req_valid = 1'b1;
    bus.m0_req_addr  = 27'h0000400;
    #1;
    check_eq("wd_rdy0", 128'(bus.m0_req_ready), 128'd1);
    tick();
    bus.m0_req_valid = 1'b0;
    for (int w = 0; w < 9; w++) begin
      tick();
      check_eq("wd_rv0_wait", 128'(bus.m0_resp_valid), 128'd0);
      check_eq("wd_busy",     128'(bus.busy),          128'd1);
    end
    tick();
    check_eq("wd_rv0",   128'(bus.m0_resp_valid), 128'd1);
    check_eq("wd_data0", bus.m0_resp_rdata,       128'd0);
    check_eq("wd_err",   128'(bus.err),           128'd1);
    check_eq("wd_idle",  128'(bus.busy),          128'd0);
    bus.dram_resp_valid = 1'b1;
    bus.dram_resp_rdata = 128'h77;
    tick();
    bus.dram_resp_valid = 1'b0;
    check_eq("wd_late_rv0", 128'(bus.m0_resp_valid), 128'd0);
    check_eq("wd_late_err", 128'(bus.err),           128'd1);
    tick();
    check_eq("wd_err_hold", 128'(bus.err),    128'd1);
    check_eq("wd_late_d0",  bus.m0_resp_rdata, 128'd0);

    // Response in the same cycle the counter reaches the limit
    do_reset();
    check_eq("lim_err_rst", 128'(bus.err), 128'd0);
    bus.m0_req_valid = 1'b1;
    bus.m0_req_addr  = 27'h0000500;
    tick();
    bus.m0_req_valid = 1'b0;
    for (int w = 0; w < 8; w++) begin
      tick();
      check_eq("lim_rv0_wait", 128'(bus.m0_resp_valid), 128'd0);
    end
    tick();
    bus.dram_resp_valid = 1'b1;
    bus.dram_resp_rdata = 128'hBEEF;
    tick();
    bus.dram_resp_valid = 1'b0;
    check_eq("lim_rv0",   128'(bus.m0_resp_valid), 128'd1);
    check_eq("lim_data0", bus.m0_resp_rdata,       128'hBEEF);
    check_eq("lim_err",   128'(bus.err),           128'd0);
    check_eq("lim_idle",  128'(bus.busy),          128'd0);
`else
    check_eq("noerr", 128'(bus.err), 128'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Two-port round-robin arbiter that shares the single DRAM request channel between two requesters, the instruction-side and data-side set-associative caches. It sits between the caches and the master side of the DRAM FIFO (`dram_buf`), which feeds `dram_controller`. It runs in the cache clock domain. It keeps at most one transaction outstanding, so responses always return in order to the requester that issued them.

## Interface
Parameters:
- `ADDR_W`, default 27: DRAM byte address width (128 MiB).
- `DATA_W`, default 128: width of one DRAM line beat.
- `WDOG_CYCLES`, default 1023: read-response timeout in cycles. Used only with `DRAM_ARB_WATCHDOG_EN`.

Ports. Clock is `clk`; reset is `rst`, **asynchronous and active-high**. `N` is 0 or 1.
- `clk` in 1: cache clock.
- `rst` in 1: asynchronous, active-high reset.
- `mN_req_valid` in 1: requester N has a request.
- `mN_req_ready` out 1: request accepted this cycle.
- `mN_req_we` in 1: 1 = write, 0 = read.
- `mN_req_addr` in `ADDR_W`: request address.
- `mN_req_wdata` in `DATA_W`: write data.
- `mN_resp_valid` out 1: read data valid, one-cycle pulse.
- `mN_resp_rdata` out `DATA_W`: read data.
- `dram_req_valid` out 1: request to the FIFO.
- `dram_req_ready` in 1: FIFO accepts the request.
- `dram_req_we` out 1: latched `we`.
- `dram_req_addr` out `ADDR_W`: latched address.
- `dram_req_wdata` out `DATA_W`: latched write data.
- `dram_resp_valid` in 1: read response from the FIFO.
- `dram_resp_rdata` in `DATA_W`: read response data.
- `busy` out 1: state is not IDLE.
- `owner` out 1: index of the requester granted most recently.
- `err` out 1: sticky watchdog flag. Constant 0 without the macro.

## Operation
State machine states: IDLE, ISSUE, WAIT.

- **IDLE**
  - Arbitration is combinational over `m0_req_valid` and `m1_req_valid`.
  - If both are valid, the requester matching the priority pointer `prio` wins. Otherwise the single valid requester wins.
  - The winner's `mN_req_ready` is 1 in the same cycle, completing a valid&&ready handshake. The loser's ready stays 0.
  - On the handshake: latch `we`, `addr` and `wdata`; set `owner` = winner; set `prio` = ~winner; go to ISSUE.
- **ISSUE**
  - `dram_req_valid` = 1, with the latched fields held stable until `dram_req_ready`.
  - On handshake with `we` = 1: go to IDLE. A write is complete once the FIFO accepts it and produces no response.
  - On handshake with `we` = 0: go to WAIT.
- **WAIT**
  - On `dram_resp_valid`: register `dram_resp_rdata` into `m[owner]_resp_rdata`, pulse `m[owner]_resp_valid` for one cycle, and go to IDLE.
- `mN_req_ready` is 0 in ISSUE and WAIT. A requester holds valid and all its fields until it sees ready.
- `dram_resp_valid` in IDLE or ISSUE is a protocol violation. It is dropped: no resp pulse and no state change.
- The non-owner's `resp_valid` is never asserted.

Reset values:
- All outputs are 0.
- `prio` = 0, `owner` = 0, state = IDLE.
- `resp_rdata` registers = 0.

Reset mid-operation: the in-flight transaction is discarded immediately, with no resp pulse. The FIFO-side cleanup is owned by the reset of `dram_buf`.

## Timing
- Grant cycle T, where `mN_req_ready` = 1, is followed by `dram_req_valid` = 1 at T+1 at the earliest.
- A write occupies the arbiter for 2 cycles minimum: accept, then issue with `dram_req_ready` already high.
- A read's response appears at the requester one cycle after `dram_resp_valid` (registered output).
- The arbiter returns to IDLE in the cycle after completion. A new grant is possible in that same IDLE cycle, so there are no idle bubbles beyond that cycle.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1,…
- A requester dropping valid without a handshake is not supported.

## Configuration
- `DRAM_ARB_WATCHDOG_EN` defined:
  - An `$clog2(WDOG_CYCLES+1)`-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `WDOG_CYCLES` without `dram_resp_valid`, the arbiter pulses `m[owner]_resp_valid` with `rdata` = 0, sets sticky `err` (cleared only by `rst`), and goes to IDLE.
  - A late response arrives in IDLE and is dropped.
  - A response arriving in the same cycle the counter reaches the limit takes precedence, and `err` is not set.
- Undefined: no counter; `err` is tied to 0; WAIT waits indefinitely.

## Test plan
- **Single read.** Stimulus: m0 read at addr 0x0000100; FIFO ready; response 0xA5…A5 three cycles after issue. Required: `m0_req_ready` at T; `dram_req_valid` at T+1 with addr 0x0000100 and we = 0; `m0_resp_valid` with 0xA5…A5 one cycle after `dram_resp_valid`; `m1_resp_valid` never 1.
- **Contention.** Stimulus: both requesters hold valid reads from reset, 4 transactions. Required: grant order 0,1,0,1; `owner` tracks each grant; each response is routed to the matching requester.
- **Back-pressure on write.** Stimulus: m1 write, data 0x1234; `dram_req_ready` low for 5 cycles. Required: `dram_req_*` stable for all 5 cycles; return to IDLE the cycle after ready; no resp pulse.
- **Reset in WAIT.** Stimulus: assert `rst` while WAIT is pending, then `dram_resp_valid` one cycle after release. Required: all outputs 0 immediately (asynchronous); the stray response is dropped; `busy` = 0.
- **Watchdog (macro defined, `WDOG_CYCLES` = 8).** Stimulus: read with no response. Required: `m0_resp_valid` with `rdata` 0 after 8 WAIT cycles; `err` = 1 and held; a later response is ignored.
- **Response at the limit (macro defined, `WDOG_CYCLES` = 8).** Stimulus: `dram_resp_valid` in the same cycle the counter hits 8. Required: real data delivered; `err` stays 0.
